mac_unit: RTL and testbench
===========================

Name: mac_unit

Overview:
Single signed fixed-point multiply-accumulate cell: result = bias_i + (data_i × weight_i) scaled by 2^-Q, registered.
One instance per kernel tap in the convolution engine. Tap cells chain through bias_i, so each registered result feeds the next cell's bias or a line-delay shift register.
Registered output, one-cycle latency, clock-enable gated.

Parameters:
DATA_WIDTH  16  width of every data/weight/bias/result word; signed two's complement
Q  5  number of fractional bits in the fixed-point format (1.0 = 2^Q); legal range 0 ≤ Q < DATA_WIDTH

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high; clears result
en  input  1  clock enable; result updates only on edges where en=1
data_i  input  DATA_WIDTH  signed fixed-point input sample
weight_i  input  DATA_WIDTH  signed fixed-point kernel weight
bias_i  input  DATA_WIDTH  signed fixed-point addend (partial sum from upstream cell, or 0)
result  output  DATA_WIDTH  registered signed fixed-point MAC result

Behaviour:
- Reset: rst=1 forces result=0 immediately, independent of clk. Result holds 0 while rst is high, including mid-operation. First update is on the first rising edge with rst=0 and en=1.
- Arithmetic (combinational, per cycle), all values signed:
  - p = data_i × weight_i, full 2·DATA_WIDTH-bit signed product.
  - ps = p arithmetic-shifted right by Q. Rounding is floor (toward −∞); there is no round-to-nearest.
  - s = ps + sign-extended bias_i, computed at 2·DATA_WIDTH+1 bits so the sum cannot wrap.
  - Saturate s to the DATA_WIDTH signed range:
    - s > 2^(DATA_WIDTH-1)-1 gives 0x7FFF (for W=16).
    - s < −2^(DATA_WIDTH-1) gives 0x8000.
    - Otherwise the low DATA_WIDTH bits of s.
- Register: on a rising clk with rst=0 and en=1, result takes the saturated value. With en=0, result holds.
- Latency: exactly 1 clock from inputs sampled (en=1) to result. Inputs are sampled only at the enabled edge.
- No handshake, no valid flag. Downstream alignment is by cycle count only.
- Inputs are required to be stable around the clock edge only. Combinational path inputs→register is allowed.
- The block has no internal state other than the result register and no X-propagation tricks. Output is fully defined after reset.

Test Plan:
(W=16, Q=5, 1.0=0x0020)
- Reset: assert rst asynchronously between edges with result≠0 -> result=0x0000 before the next edge; hold 0 while rst=1 even with en=1.
- Basic MAC: data=0x0040 (2.0), weight=0x0060 (3.0), bias=0x0020, en=1 -> next cycle result=0x00E0 (7.0). Then en=0 with changed inputs -> result stays 0x00E0.
- Signed/floor:
  - data=0xFFC0 (−2.0), weight=0x0060, bias=0 -> 0xFF40.
  - data=0x0001, weight=0x0001, bias=0 -> 0x0000.
  - data=0xFFFF, weight=0x0001, bias=0 -> 0xFFFF (floor of −1/32).
- Product saturation:
  - data=0x7FFF, weight=0x7FFF, bias=0 -> 0x7FFF.
  - data=0x8000, weight=0x7FFF, bias=0 -> 0x8000.
- Bias-add saturation:
  - data=0x0020, weight=0x7000, bias=0x7000 -> 0x7FFF.
  - data=0x0020, weight=0x9000, bias=0x9000 -> 0x8000.
- Pipelined stream: change inputs every cycle with en=1 for 20 random vectors -> each result equals the reference-model value of the previous cycle's inputs. Toggling en=0 for random cycles freezes result and skips those inputs.

Source files
------------

// File: rtl/mac_if.sv
// mac_if: operand and result bundle for one mac_unit tap
interface mac_if #(parameter int DATA_WIDTH = 16);
    logic en;
    logic signed [DATA_WIDTH-1:0] data_i;
    logic signed [DATA_WIDTH-1:0] weight_i;
    logic signed [DATA_WIDTH-1:0] bias_i;
    logic signed [DATA_WIDTH-1:0] result;
    modport master(output en, data_i, weight_i, bias_i, input result);
    modport slave(input en, data_i, weight_i, bias_i, output result);
endinterface

// File: rtl/mac_unit.sv
// mac_unit: registered saturating fixed-point multiply-accumulate tap
module mac_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int Q = 5
) (
    input logic clk,
    input logic rst,
    mac_if.slave m
);
    localparam int PW = 2 * DATA_WIDTH;
    logic signed [PW-1:0] p;
    logic signed [PW-1:0] ps;
    logic signed [PW:0] s;
    logic ovf;
    logic signed [DATA_WIDTH-1:0] sat;
    assign p = PW'(m.data_i) * PW'(m.weight_i);
    assign ps = p >>> Q;
    assign s = (PW + 1)'(ps) + (PW + 1)'(m.bias_i);
    // in range only when every bit above the result sign bit matches it
    assign ovf = !(&s[PW:DATA_WIDTH-1] || ~|s[PW:DATA_WIDTH-1]);
    assign sat = !ovf ? s[DATA_WIDTH-1:0]
               : s[PW] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
               : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    always_ff @(posedge clk or posedge rst)
        if (rst) m.result <= '0;
        else if (m.en) m.result <= sat;
endmodule

// File: tb/tb_mac_unit.sv
// tb_mac_unit: scoreboard bench for mac_unit (W=16, Q=5)
module tb_mac_unit;
    logic clk = 0;
    logic rst = 1;
    int errors = 0;
    int checks = 0;
    logic [15:0] sb[$];
    mac_if #(.DATA_WIDTH(16)) mi();
    mac_unit #(.DATA_WIDTH(16), .Q(5)) dut(.clk(clk), .rst(rst), .m(mi));
    always #5 clk = ~clk;
    function automatic logic [15:0] ref_mac(logic signed [15:0] d, logic signed [15:0] w,
                                            logic signed [15:0] b);
        longint v;
        v = (longint'(d) * longint'(w)) >>> 5;
        v = v + longint'(b);
        if (v > 32767) return 16'h7FFF;
        if (v < -32768) return 16'h8000;
        return 16'(v);
    endfunction
    task automatic check(string name, logic [15:0] act, logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, req);
        end
    endtask
    task automatic apply(logic [15:0] d, logic [15:0] w, logic [15:0] b, logic e, logic [15:0] exp);
        @(negedge clk);
        mi.data_i = d;
        mi.weight_i = w;
        mi.bias_i = b;
        mi.en = e;
        if (e && !rst) sb.push_back(exp);
    endtask
    logic [15:0] last_exp = '0;
    logic take;
    logic [15:0] e_val;
    always @(posedge clk) begin
        take = mi.en && !rst;
        #1;
        if (rst) last_exp = '0;
        else if (take) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL scoreboard_underflow: got update, expected none queued");
            end else begin
                e_val = sb.pop_front();
                check("mac_result", mi.result, e_val);
                last_exp = e_val;
            end
        end else check("hold", mi.result, last_exp);
    end
    initial begin
        logic [15:0] d, w, b;
        mi.en = 0;
        mi.data_i = 0;
        mi.weight_i = 0;
        mi.bias_i = 0;
        #2;
        check("reset_init", mi.result, 16'h0000);
        @(negedge clk);
        rst = 0;
        apply(16'h0040, 16'h0060, 16'h0020, 1, 16'h00E0);
        apply(16'h1234, 16'h0567, 16'h0100, 0, 16'h0000);
        apply(16'h7777, 16'h0011, 16'h0001, 0, 16'h0000);
        @(posedge clk);
        #3;
        rst = 1;
        #1;
        check("async_reset", mi.result, 16'h0000);
        apply(16'h0040, 16'h0060, 16'h0020, 1, 16'h0000);
        apply(16'h0040, 16'h0060, 16'h0020, 1, 16'h0000);
        check("reset_hold", mi.result, 16'h0000);
        @(negedge clk);
        mi.en = 0;
        rst = 0;
        apply(16'hFFC0, 16'h0060, 16'h0000, 1, 16'hFF40);
        apply(16'h0001, 16'h0001, 16'h0000, 1, 16'h0000);
        apply(16'hFFFF, 16'h0001, 16'h0000, 1, 16'hFFFF);
        apply(16'h7FFF, 16'h7FFF, 16'h0000, 1, 16'h7FFF);
        apply(16'h8000, 16'h7FFF, 16'h0000, 1, 16'h8000);
        apply(16'h0020, 16'h7000, 16'h7000, 1, 16'h7FFF);
        apply(16'h0020, 16'h9000, 16'h9000, 1, 16'h8000);
        apply(16'h0040, 16'h0060, 16'h0020, 1, 16'h00E0);
        for (int i = 0; i < 20; i++) begin
            d = 16'($urandom);
            w = 16'($urandom);
            b = 16'($urandom);
            apply(d, w, b, 1'($urandom_range(0, 3) != 0), ref_mac(d, w, b));
        end
        apply(16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
        apply(16'h0000, 16'h0000, 16'h0000, 0, 16'h0000);
        @(negedge clk);
        check("scoreboard_empty", 16'(sb.size()), 16'h0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
